md_scheduler: RTL
=================

Name: md_scheduler

Overview:
- Multiply/divide sequencer for the 5-stage pipeline. Accepts mult/multu/div/divu/mthi/mtlo from the E stage and runs a fixed-latency busy counter. Owns the HI/LO registers.
- Generates the write-enable/flush controls for the F/D/E/M/W pipeline registers. Merges the external data-hazard stall with its own md stall.
- Sits beside the E stage. Its outputs drive the WE/Flush pins of every pipeline register.

Parameters:
- MULT_LAT, 5, cycles busy for mult/multu (>=1)
- DIV_LAT, 10, cycles busy for div/divu (>=1)
- CNT_W, 4, counter width; must hold max(MULT_LAT, DIV_LAT)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- E_start  in  1  E-stage instruction is an md op (from E decode)
- E_md_op  in  3  md opcode, package encoding
- E_A  in  32  rs operand (forwarded)
- E_B  in  32  rt operand (forwarded)
- D_use_md  in  1  D-stage instruction is any md op or mfhi/mflo
- hazard_stall  in  1  data-hazard stall from the hazard unit
- busy  out  1  md operation in progress
- HI  out  32  HI register
- LO  out  32  LO register
- F_WE  out  1  PC/F enable
- D_WE  out  1  D register enable
- E_Flush  out  1  insert bubble into E register
- M_WE  out  1  M register enable
- W_WE  out  1  W register enable

Behaviour:
- Reset: busy=0, HI=0, LO=0, counter=0, pending result=0. Reset mid-operation aborts it: no HI/LO update afterwards.
- Reset outputs: F_WE=1, D_WE=1, E_Flush=0, M_WE=1, W_WE=1.
- busy is 1 whenever counter!=0.
- Start edge (E_start=1, busy=0, op is MULT/MULTU/DIV/DIVU):
  - Compute the 64-bit result from E_A/E_B into the pending registers.
  - Load the counter with MULT_LAT or DIV_LAT. busy rises after this edge.
- Each edge with counter>1: decrement.
- Edge with counter==1: HI/LO <= pending, counter <= 0. busy is high for exactly LAT cycles, and HI/LO become visible in the same cycle busy falls.
- MULT: signed 32x32 -> 64, {HI,LO}=product.
- MULTU: unsigned 32x32 -> 64, {HI,LO}=product.
- DIV: signed; LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
- DIVU: unsigned; LO=quotient, HI=remainder.
- DIV/DIVU with E_B=0: still busy for DIV_LAT cycles; HI/LO unchanged at completion.
- MTHI/MTLO (E_start=1, busy=0): HI or LO <= E_A at that edge. Counter untouched, no busy.
- E_start=1 while busy=1 is a protocol violation; it cannot occur because of the stall below. The block ignores it, and the bench asserts it never happens.
- Reserved opcodes 6/7 are ignored.
- md_stall = D_use_md & (busy | E_start), combinational. This covers back-to-back md ops and mfhi/mflo reading an in-flight result.
- stall = hazard_stall | md_stall.
- Pipeline controls: F_WE=~stall, D_WE=~stall, E_Flush=stall, M_WE=1, W_WE=1. These are combinational from the inputs and busy.
- HI/LO outputs come straight from the registers; no bypass of the pending result.

Decomposition:
- Shared package md_pkg:
  - MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5
  - default latency constants
- One sub-module, md_core: the combinational 64-bit result calculation for the four arithmetic ops plus the divide-by-zero flag.
- The counter, HI/LO and stall logic stay in md_scheduler.

Test Plan:
- mult E_A=-3 (0xFFFFFFFD), E_B=7 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- divu E_A=100, E_B=7 -> busy 10 cycles; then LO=14, HI=2. Then div E_A=-7, E_B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mult issued, next cycle D_use_md=1 (mflo) -> F_WE=D_WE=0 and E_Flush=1 on every busy cycle; released in the cycle busy=0; LO then holds the product.
- mthi E_A=0x12345678, then mtlo E_A=0x9ABCDEF0 -> HI/LO updated on the next edge each; busy never asserts.
- div with E_B=0 after mthi/mtlo preload -> busy 10 cycles; HI/LO keep the preload values.
- mult started, reset pulsed at counter=3 -> busy=0, HI=LO=0 next cycle; no late write after reset releases. hazard_stall=1 alone -> F_WE=D_WE=0, E_Flush=1, M_WE=W_WE=1.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide sequencer.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int unsigned MD_MULT_LAT_DEF = 5;
  localparam int unsigned MD_DIV_LAT_DEF  = 10;
  localparam int unsigned MD_CNT_W_DEF    = 4;
  localparam int unsigned MD_DATA_W       = 32;
  localparam int unsigned MD_RES_W        = 64;

  // True for the four ops that occupy the busy counter.
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_core.sv
// Combinational 64-bit {HI,LO} result for mult/multu/div/divu plus divide-by-zero flag.
module md_core
  import md_pkg::*;
(
  input  logic [2:0]           op,
  input  logic [MD_DATA_W-1:0] a,
  input  logic [MD_DATA_W-1:0] b,
  output logic [MD_RES_W-1:0]  res_c,
  output logic                 div_zero_c
);

  logic                        b_zero;
  logic [MD_DATA_W-1:0]        b_safe;
  logic signed [MD_DATA_W-1:0] sa;
  logic signed [MD_DATA_W-1:0] sb;
  logic signed [MD_RES_W-1:0]  prod_s;
  logic [MD_RES_W-1:0]         prod_u;
  logic signed [MD_DATA_W-1:0] quot_s;
  logic signed [MD_DATA_W-1:0] rem_s;
  logic [MD_DATA_W-1:0]        quot_u;
  logic [MD_DATA_W-1:0]        rem_u;

  // A zero divisor is replaced by 1 so the dividers never see x; the result is discarded anyway.
  assign b_zero = (b == '0);
  assign b_safe = b_zero ? MD_DATA_W'(1) : b;
  assign sa     = $signed(a);
  assign sb     = $signed(b_safe);

  assign prod_s = MD_RES_W'(sa) * MD_RES_W'($signed(b));
  assign prod_u = MD_RES_W'(a) * MD_RES_W'(b);
  assign quot_s = sa / sb;
  assign rem_s  = sa % sb;
  assign quot_u = a / b_safe;
  assign rem_u  = a % b_safe;

  assign div_zero_c = md_is_div(op) && b_zero;

  always_comb begin
    res_c = '0;
    case (op)
      MD_MULT:  res_c = prod_s;
      MD_MULTU: res_c = prod_u;
      MD_DIV:   res_c = {rem_s, quot_s};
      MD_DIVU:  res_c = {rem_u, quot_u};
      default:  res_c = '0;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// Multiply/divide sequencer: busy counter, HI/LO ownership and pipeline stall/flush controls.
module md_scheduler
  import md_pkg::*;
#(
  parameter int unsigned MULT_LAT = MD_MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = MD_DIV_LAT_DEF,
  parameter int unsigned CNT_W    = MD_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 E_start,
  input  logic [2:0]           E_md_op,
  input  logic [MD_DATA_W-1:0] E_A,
  input  logic [MD_DATA_W-1:0] E_B,
  input  logic                 D_use_md,
  input  logic                 hazard_stall,
  output logic                 busy,
  output logic [MD_DATA_W-1:0] HI,
  output logic [MD_DATA_W-1:0] LO,
  output logic                 F_WE,
  output logic                 D_WE,
  output logic                 E_Flush,
  output logic                 M_WE,
  output logic                 W_WE
);

  logic [CNT_W-1:0]    cnt;
  logic [MD_RES_W-1:0] pend;
  logic                pend_we;
  logic [MD_RES_W-1:0] res_c;
  logic                div_zero_c;
  logic                md_stall_c;
  logic                stall_c;

  md_core u_core (
    .op         (E_md_op),
    .a          (E_A),
    .b          (E_B),
    .res_c      (res_c),
    .div_zero_c (div_zero_c)
  );

  // Result is captured at issue and only committed to HI/LO on the final busy edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pend    <= '0;
      pend_we <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else if (cnt == CNT_W'(1)) begin
      cnt <= '0;
      if (pend_we) begin
        HI <= pend[MD_RES_W-1:MD_DATA_W];
        LO <= pend[MD_DATA_W-1:0];
      end
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end else if (E_start) begin
      if (md_is_arith(E_md_op)) begin
        pend    <= res_c;
        pend_we <= ~div_zero_c;
        cnt     <= md_is_div(E_md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      end else if (E_md_op == MD_MTHI) begin
        HI <= E_A;
      end else if (E_md_op == MD_MTLO) begin
        LO <= E_A;
      end
    end
  end

  assign busy       = (cnt != '0);
  assign md_stall_c = D_use_md & (busy | E_start);
  assign stall_c    = hazard_stall | md_stall_c;

  assign F_WE    = ~stall_c;
  assign D_WE    = ~stall_c;
  assign E_Flush = stall_c;
  assign M_WE    = 1'b1;
  assign W_WE    = 1'b1;

endmodule
